// File: rtl/pacman_move_ctrl.sv
// Per-frame Pac-Man movement controller: turns the latched key into a legal move via wall lookups.
// Optional macro PAC_TUNNEL_EN: horizontal neighbours wrap through the side tunnel.
`timescale 1ns/1ps
module pacman_move_ctrl #(
    parameter int TILE_SHIFT = 3,
    parameter int STEP       = 1,
    parameter int MAZE_W     = 28,
    parameter int MAZE_H     = 31,
    parameter int START_X    = 104,
    parameter int START_Y    = 184
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic       wall_req,
    output logic [4:0] wall_tx,
    output logic [4:0] wall_ty,
    input  logic       wall_ack,
    input  logic       wall_blocked,
    output logic [9:0] PacX,
    output logic [9:0] PacY,
    output logic [1:0] PacDir,
    output logic       moving,
    output logic       busy
);

    typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1, DIR_DOWN = 2'd2, DIR_UP = 2'd3} dir_e;
    typedef enum logic [1:0] {IDLE, Q_PEND, Q_CUR, MOVE} state_e;

`ifdef PAC_TUNNEL_EN
    localparam logic [9:0] WRAP_X = 10'((MAZE_W << TILE_SHIFT) - STEP);
`endif

    state_e     state_q, state_d;
    dir_e       pend_dir, key_dir, q_dir;
    logic       pend_v, key_valid, held_tick, req_gap;
    logic [9:0] tile_x, tile_y, step_x, step_y;
    logic [4:0] nb_tx, nb_ty;
    logic       nb_oob, aligned, in_query, go, fire, issue, oob_hit;
    logic       adopt, stop;

    assign busy     = (state_q != IDLE);
    assign tile_x   = PacX >> TILE_SHIFT;
    assign tile_y   = PacY >> TILE_SHIFT;
    assign aligned  = (PacX[TILE_SHIFT-1:0] == '0) && (PacY[TILE_SHIFT-1:0] == '0);
    assign go       = frame_tick || held_tick;
    assign fire     = wall_req && wall_ack;
    assign in_query = (state_q == Q_PEND) || (state_q == Q_CUR);
    assign q_dir    = (state_q == Q_PEND) ? pend_dir : dir_e'(PacDir);
    // req_gap keeps wall_req low one extra cycle after a handshake so a stale ack cannot be reused.
    assign issue    = in_query && !wall_req && !req_gap && !nb_oob;
    assign oob_hit  = in_query && !wall_req && !req_gap && nb_oob;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        key_valid = 1'b1;
        key_dir   = DIR_RIGHT;
        case (keycode)
            8'h04:   key_dir = DIR_LEFT;
            8'h07:   key_dir = DIR_RIGHT;
            8'h16:   key_dir = DIR_DOWN;
            8'h1A:   key_dir = DIR_UP;
            default: key_valid = 1'b0;
        endcase
    end

    always_comb begin
        nb_tx  = tile_x[4:0];
        nb_ty  = tile_y[4:0];
        nb_oob = 1'b0;
        case (q_dir)
            DIR_RIGHT:
                if (tile_x >= 10'(MAZE_W - 1)) begin
`ifdef PAC_TUNNEL_EN
                    nb_tx = '0;
`else
                    nb_oob = 1'b1;
`endif
                end else begin
                    nb_tx = 5'(tile_x + 10'd1);
                end
            DIR_LEFT:
                if (tile_x == '0) begin
`ifdef PAC_TUNNEL_EN
                    nb_tx = 5'(MAZE_W - 1);
`else
                    nb_oob = 1'b1;
`endif
                end else begin
                    nb_tx = 5'(tile_x - 10'd1);
                end
            DIR_DOWN:
                if (tile_y >= 10'(MAZE_H - 1)) nb_oob = 1'b1;
                else                           nb_ty  = 5'(tile_y + 10'd1);
            DIR_UP:
                if (tile_y == '0) nb_oob = 1'b1;
                else              nb_ty  = 5'(tile_y - 10'd1);
        endcase
    end

    always_comb begin
        step_x = PacX;
        step_y = PacY;
        case (dir_e'(PacDir))
            DIR_RIGHT: step_x = PacX + 10'(STEP);
            DIR_LEFT:  step_x = PacX - 10'(STEP);
            DIR_DOWN:  step_y = PacY + 10'(STEP);
            DIR_UP:    step_y = PacY - 10'(STEP);
        endcase
`ifdef PAC_TUNNEL_EN
        if (PacDir == DIR_LEFT  && PacX == '0)    step_x = WRAP_X;
        if (PacDir == DIR_RIGHT && PacX == WRAP_X) step_x = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        adopt   = 1'b0;
        stop    = 1'b0;
        case (state_q)
            IDLE:
                if (go) begin
                    if (pend_v && (pend_dir == dir_e'(PacDir ^ 2'b01))) begin
                        adopt   = 1'b1;
                        state_d = MOVE;
                    end else if (aligned && pend_v) begin
                        state_d = Q_PEND;
                    end else if (aligned) begin
                        state_d = Q_CUR;
                    end else begin
                        state_d = MOVE;
                    end
                end
            Q_PEND:
                if (oob_hit || (fire && wall_blocked)) begin
                    state_d = Q_CUR;
                end else if (fire) begin
                    adopt   = 1'b1;
                    state_d = MOVE;
                end
            Q_CUR:
                if (oob_hit || (fire && wall_blocked)) begin
                    stop    = 1'b1;
                    state_d = IDLE;
                end else if (fire) begin
                    state_d = MOVE;
                end
            MOVE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses <= so all flops update from pre-edge values, free of ordering races.
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            PacX      <= 10'(START_X);
            PacY      <= 10'(START_Y);
            PacDir    <= DIR_LEFT;
            moving    <= 1'b0;
            wall_req  <= 1'b0;
            wall_tx   <= '0;
            wall_ty   <= '0;
            pend_v    <= 1'b0;
            pend_dir  <= DIR_RIGHT;
            held_tick <= 1'b0;
            req_gap   <= 1'b0;
        end else begin
            // A key arriving in the same cycle as a turn is adopted stays pending.
            if (key_valid) begin
                pend_dir <= key_dir;
                pend_v   <= 1'b1;
            end else if (adopt) begin
                pend_v <= 1'b0;
            end
            if (adopt) PacDir <= pend_dir;

            if (issue) begin
                wall_req <= 1'b1;
                wall_tx  <= nb_tx;
                wall_ty  <= nb_ty;
            end else if (fire) begin
                wall_req <= 1'b0;
            end
            req_gap <= fire;

            if (busy && frame_tick)  held_tick <= 1'b1;
            else if (!busy && go)    held_tick <= 1'b0;

            if (state_q == MOVE) begin
                PacX   <= step_x;
                PacY   <= step_y;
                moving <= 1'b1;
            end else if (stop) begin
                moving <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed self-checking bench for pacman_move_ctrl with a programmable-latency wall responder.
`timescale 1ns/1ps
module tb_pacman_move_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       wall_req;
    logic [4:0] wall_tx, wall_ty;
    logic       wall_ack = 1'b0;
    logic       wall_blocked = 1'b0;
    logic [9:0] pac_x, pac_y;
    logic [1:0] pac_dir;
    logic       moving, busy;

    int total = 0;
    int bad = 0;
    int req_count = 0;
    int ack_lat = 1;
    int ack_cnt = 0;
    logic prev_req = 1'b0;
    logic [4:0] cap_tx = '0, cap_ty = '0;
    bit wall_map [32][32];

    pacman_move_ctrl dut (
        .Clk          (clk),
        .Reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .keycode      (keycode),
        .wall_req     (wall_req),
        .wall_tx      (wall_tx),
        .wall_ty      (wall_ty),
        .wall_ack     (wall_ack),
        .wall_blocked (wall_blocked),
        .PacX         (pac_x),
        .PacY         (pac_y),
        .PacDir       (pac_dir),
        .moving       (moving),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Maze responder: acks after ack_lat cycles of wall_req, answering from wall_map.
    always @(negedge clk) begin
        if (wall_req && !wall_ack) begin
            ack_cnt = ack_cnt + 1;
            if (ack_cnt >= ack_lat) begin
                wall_ack     = 1'b1;
                wall_blocked = wall_map[wall_tx][wall_ty];
                ack_cnt      = 0;
            end
        end else begin
            wall_ack     = 1'b0;
            wall_blocked = 1'b0;
            ack_cnt      = 0;
        end
    end

    // Request monitor: counts requests, captures their tile, and checks it stays stable.
    always @(negedge clk) begin
        if (wall_req) begin
            if (!prev_req) begin
                req_count = req_count + 1;
                cap_tx    = wall_tx;
                cap_ty    = wall_ty;
            end else begin
                total++;
                if (wall_tx !== cap_tx || wall_ty !== cap_ty) begin
                    bad++;
                    $display("FAIL addr_stable got=(%0d,%0d) exp=(%0d,%0d)", wall_tx, wall_ty, cap_tx, cap_ty);
                end
            end
        end
        prev_req = wall_req;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_map();
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                wall_map[x][y] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        keycode    = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        #1;
        while (busy && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL idle_timeout got busy=%0b exp busy=0", busy);
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            wait_idle();
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(negedge clk);
        keycode = k;
        @(negedge clk);
        keycode = 8'h00;
    endtask

    task automatic test_reset();
        clear_map();
        ack_lat = 1;
        do_reset();
        total++; if (pac_x !== 10'd104) begin bad++; $display("FAIL reset_x got=%0d exp=104", pac_x); end
        total++; if (pac_y !== 10'd184) begin bad++; $display("FAIL reset_y got=%0d exp=184", pac_y); end
        total++; if (pac_dir !== 2'd1) begin bad++; $display("FAIL reset_dir got=%0d exp=1", pac_dir); end
        total++; if (moving !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_flags got moving=%0b busy=%0b exp 0 0", moving, busy); end
        total++; if (wall_req !== 1'b0 || wall_tx !== 5'd0 || wall_ty !== 5'd0) begin
            bad++; $display("FAIL reset_req got req=%0b tx=%0d ty=%0d exp 0 0 0", wall_req, wall_tx, wall_ty);
        end
    endtask

    task automatic test_straight();
        int rc0;
        do_reset();
        rc0 = req_count;
        tick();
        repeat (2) @(negedge clk);
        total++; if (pac_x !== 10'd104) begin bad++; $display("FAIL lat1_early got=%0d exp=104", pac_x); end
        @(negedge clk);
        total++; if (pac_x !== 10'd103) begin bad++; $display("FAIL lat1_update got=%0d exp=103", pac_x); end
        wait_idle();
        total++; if (req_count !== rc0 + 1 || cap_tx !== 5'd12 || cap_ty !== 5'd23) begin
            bad++; $display("FAIL first_query got n=%0d tile=(%0d,%0d) exp n=%0d tile=(12,23)", req_count - rc0, cap_tx, cap_ty, 1);
        end
        run_ticks(7);
        total++; if (pac_x !== 10'd96 || pac_y !== 10'd184) begin bad++; $display("FAIL straight_pos got=(%0d,%0d) exp=(96,184)", pac_x, pac_y); end
        total++; if (pac_dir !== 2'd1 || moving !== 1'b1) begin bad++; $display("FAIL straight_dir got dir=%0d moving=%0b exp 1 1", pac_dir, moving); end
        total++; if (req_count !== rc0 + 1) begin bad++; $display("FAIL straight_reqs got=%0d exp=1", req_count - rc0); end
        run_ticks(1);
        total++; if (cap_tx !== 5'd11 || cap_ty !== 5'd23 || pac_x !== 10'd95) begin
            bad++; $display("FAIL second_query got tile=(%0d,%0d) x=%0d exp tile=(11,23) x=95", cap_tx, cap_ty, pac_x);
        end
    endtask

    task automatic test_turn();
        int rc0;
        do_reset();
        run_ticks(4);
        press(8'h1A);
        run_ticks(4);
        total++; if (pac_x !== 10'd96 || pac_y !== 10'd184 || pac_dir !== 2'd1) begin
            bad++; $display("FAIL turn_wait got x=%0d y=%0d dir=%0d exp 96 184 1", pac_x, pac_y, pac_dir);
        end
        rc0 = req_count;
        run_ticks(1);
        total++; if (req_count !== rc0 + 1 || cap_tx !== 5'd12 || cap_ty !== 5'd22) begin
            bad++; $display("FAIL turn_query got n=%0d tile=(%0d,%0d) exp n=1 tile=(12,22)", req_count - rc0, cap_tx, cap_ty);
        end
        total++; if (pac_dir !== 2'd3 || pac_x !== 10'd96 || pac_y !== 10'd183) begin
            bad++; $display("FAIL turn_move got dir=%0d x=%0d y=%0d exp 3 96 183", pac_dir, pac_x, pac_y);
        end
    endtask

    task automatic test_reversal();
        int rc0;
        do_reset();
        run_ticks(4);
        press(8'h07);
        rc0 = req_count;
        tick();
        total++; if (pac_x !== 10'd100) begin bad++; $display("FAIL rev_early got=%0d exp=100", pac_x); end
        @(negedge clk);
        total++; if (pac_x !== 10'd101 || pac_dir !== 2'd0) begin bad++; $display("FAIL rev_move got x=%0d dir=%0d exp 101 0", pac_x, pac_dir); end
        wait_idle();
        total++; if (req_count !== rc0 || dut.pend_v !== 1'b0) begin
            bad++; $display("FAIL rev_noreq got n=%0d pend_v=%0b exp 0 0", req_count - rc0, dut.pend_v);
        end
    endtask

    task automatic test_blocked();
        int rc0;
        do_reset();
        run_ticks(8);
        wall_map[11][23] = 1'b1;
        wall_map[12][22] = 1'b1;
        press(8'h1A);
        for (int t = 0; t < 2; t++) begin
            rc0 = req_count;
            run_ticks(1);
            total++; if (req_count !== rc0 + 2 || moving !== 1'b0) begin
                bad++; $display("FAIL blocked_reqs got n=%0d moving=%0b exp 2 0", req_count - rc0, moving);
            end
            total++; if (pac_x !== 10'd96 || pac_y !== 10'd184 || pac_dir !== 2'd1 || dut.pend_v !== 1'b1) begin
                bad++; $display("FAIL blocked_hold got x=%0d y=%0d dir=%0d pend=%0b exp 96 184 1 1", pac_x, pac_y, pac_dir, dut.pend_v);
            end
        end
        wall_map[11][23] = 1'b0;
        rc0 = req_count;
        tick();
        repeat (5) @(negedge clk);
        total++; if (pac_x !== 10'd96) begin bad++; $display("FAIL lat2_early got=%0d exp=96", pac_x); end
        @(negedge clk);
        total++; if (pac_x !== 10'd95) begin bad++; $display("FAIL lat2_update got=%0d exp=95", pac_x); end
        wait_idle();
        total++; if (req_count !== rc0 + 2 || pac_dir !== 2'd1 || dut.pend_v !== 1'b1) begin
            bad++; $display("FAIL retry_state got n=%0d dir=%0d pend=%0b exp 2 1 1", req_count - rc0, pac_dir, dut.pend_v);
        end
        clear_map();
    endtask

    task automatic test_held_tick();
        int rc0;
        do_reset();
        ack_lat = 5;
        rc0 = req_count;
        tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (pac_x !== 10'd104) begin bad++; $display("FAIL slow_early got=%0d exp=104", pac_x); end
        @(negedge clk);
        total++; if (pac_x !== 10'd103) begin bad++; $display("FAIL slow_update got=%0d exp=103", pac_x); end
        repeat (15) @(negedge clk);
        #1;
        total++; if (pac_x !== 10'd102 || busy !== 1'b0) begin bad++; $display("FAIL held_once got x=%0d busy=%0b exp 102 0", pac_x, busy); end
        total++; if (req_count !== rc0 + 1) begin bad++; $display("FAIL held_reqs got=%0d exp=1", req_count - rc0); end
        ack_lat = 1;
    endtask

    task automatic test_reset_mid_lookup();
        do_reset();
        ack_lat = 5;
        tick();
        repeat (2) @(negedge clk);
        total++; if (wall_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%0b exp=1", wall_req); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++; if (wall_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset got req=%0b busy=%0b exp 0 0", wall_req, busy); end
        repeat (10) @(negedge clk);
        total++; if (pac_x !== 10'd104 || busy !== 1'b0 || moving !== 1'b0) begin
            bad++; $display("FAIL after_reset got x=%0d busy=%0b moving=%0b exp 104 0 0", pac_x, busy, moving);
        end
        ack_lat = 1;
    endtask

    task automatic test_tunnel();
        int rc0;
        do_reset();
        run_ticks(104);
        total++; if (pac_x !== 10'd0) begin bad++; $display("FAIL edge_reach got=%0d exp=0", pac_x); end
        rc0 = req_count;
        run_ticks(1);
`ifdef PAC_TUNNEL_EN
        total++; if (req_count !== rc0 + 1 || cap_tx !== 5'd27 || cap_ty !== 5'd23) begin
            bad++; $display("FAIL tunnel_query got n=%0d tile=(%0d,%0d) exp 1 (27,23)", req_count - rc0, cap_tx, cap_ty);
        end
        total++; if (pac_x !== 10'd223 || moving !== 1'b1) begin bad++; $display("FAIL tunnel_wrap got x=%0d moving=%0b exp 223 1", pac_x, moving); end
`else
        total++; if (req_count !== rc0) begin bad++; $display("FAIL edge_noreq got=%0d exp=0", req_count - rc0); end
        total++; if (pac_x !== 10'd0 || moving !== 1'b0) begin bad++; $display("FAIL edge_stop got x=%0d moving=%0b exp 0 0", pac_x, moving); end
`endif
    endtask

    initial begin
        test_reset();
        test_straight();
        test_turn();
        test_reversal();
        test_blocked();
        test_held_tick();
        test_reset_mid_lookup();
        test_tunnel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
